// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for one pipeline stage: the upstream offer and the downstream
// presentation.
// Signal names match the stage's port list. The slave modport is the view the stage itself
// uses.
interface pipe_skid_stage_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned EXC_W  = 1
) ();

  logic              up_valid_i;
  logic              up_ready_o;
  logic [PC_W-1:0]   up_pc_i;
  logic [INST_W-1:0] up_inst_i;
  logic [EXC_W-1:0]  up_exc_i;

  logic              dn_valid_o;
  logic              dn_ready_i;
  logic [PC_W-1:0]   dn_pc_o;
  logic [INST_W-1:0] dn_inst_o;
  logic [EXC_W-1:0]  dn_exc_o;

  // Environment side: drives the upstream offer and the downstream ready.
  modport master (
    output up_valid_i, up_pc_i, up_inst_i, up_exc_i, dn_ready_i,
    input  up_ready_o, dn_valid_o, dn_pc_o, dn_inst_o, dn_exc_o
  );

  // Stage side.
  modport slave (
    input  up_valid_i, up_pc_i, up_inst_i, up_exc_i, dn_ready_i,
    output up_ready_o, dn_valid_o, dn_pc_o, dn_inst_o, dn_exc_o
  );

endinterface

// File: rtl/pipe_skid_stage.sv
// Generic inter-stage pipeline register with a 2-entry skid buffer. It carries PC, instruction
// and exception flags.
// up_ready_o is a flop output, so there is no combinational path from dn_ready_i.
module pipe_skid_stage #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned EXC_W       = 1,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  pipe_skid_stage_if.slave       bus,
  output logic [1:0]             occupancy_o
);

  // Encoding chosen so bit 0 is OUT.valid and bit 1 is SKD.valid. With this choice every
  // handshake output is a direct flop bit.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0]   out_pc_q, skd_pc_q;
  logic [INST_W-1:0] out_inst_q, skd_inst_q;
  logic [EXC_W-1:0]  out_exc_q, skd_exc_q;

  logic out_valid, skd_valid;
  logic in_fire, out_fire;
  logic load_out, out_from_skd, load_skd;

  assign out_valid = state_q[0];
  assign skd_valid = state_q[1];

  assign in_fire  = bus.up_valid_i & ~skd_valid;
  assign out_fire = out_valid & bus.dn_ready_i;

  // Next-state and load-enable decode; flush overrides any handshake on the same cycle.
  always_comb begin
    state_d      = state_q;
    load_out     = 1'b0;
    out_from_skd = 1'b0;
    load_skd     = 1'b0;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d  = StOne;
            load_out = 1'b1;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            load_out = 1'b1;
          end else if (in_fire) begin
            state_d  = StFull;
            load_skd = 1'b1;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d      = StOne;
            load_out     = 1'b1;
            out_from_skd = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State and payload registers. Flush zeroes OUT so the bubble is clean in both ZERO_BUBBLE
  // modes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StEmpty;
      out_pc_q   <= '0;
      out_inst_q <= '0;
      out_exc_q  <= '0;
      skd_pc_q   <= '0;
      skd_inst_q <= '0;
      skd_exc_q  <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        out_pc_q   <= '0;
        out_inst_q <= '0;
        out_exc_q  <= '0;
      end else if (load_out) begin
        out_pc_q   <= out_from_skd ? skd_pc_q   : bus.up_pc_i;
        out_inst_q <= out_from_skd ? skd_inst_q : bus.up_inst_i;
        out_exc_q  <= out_from_skd ? skd_exc_q  : bus.up_exc_i;
      end
      if (load_skd) begin
        skd_pc_q   <= bus.up_pc_i;
        skd_inst_q <= bus.up_inst_i;
        skd_exc_q  <= bus.up_exc_i;
      end
    end
  end

  assign bus.up_ready_o = ~skd_valid;
  assign bus.dn_valid_o = out_valid;
  assign occupancy_o    = {skd_valid, out_valid & ~skd_valid};

  // Payload outputs, masked to zero on empty cycles when ZERO_BUBBLE is set.
  always_comb begin
    bus.dn_pc_o   = out_pc_q;
    bus.dn_inst_o = out_inst_q;
    bus.dn_exc_o  = out_exc_q;
    if (ZERO_BUBBLE && !out_valid) begin
      bus.dn_pc_o   = '0;
      bus.dn_inst_o = '0;
      bus.dn_exc_o  = '0;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage. Instance a uses ZERO_BUBBLE=1 and is tracked by a
// scoreboard. Instance b uses ZERO_BUBBLE=0.
module tb_pipe_skid_stage;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned EXC_W  = 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [EXC_W-1:0]  exc;
  } entry_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic a_flush, b_flush;
  logic [1:0] a_occ, b_occ;

  int checks = 0;
  int errors = 0;
  entry_t sb[$];

  pipe_skid_stage_if #(.PC_W(PC_W), .INST_W(INST_W), .EXC_W(EXC_W)) a_if ();
  pipe_skid_stage_if #(.PC_W(PC_W), .INST_W(INST_W), .EXC_W(EXC_W)) b_if ();

  pipe_skid_stage #(
    .PC_W(PC_W), .INST_W(INST_W), .EXC_W(EXC_W), .ZERO_BUBBLE(1'b1)
  ) u_dut_a (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (a_flush),
    .bus         (a_if),
    .occupancy_o (a_occ)
  );

  pipe_skid_stage #(
    .PC_W(PC_W), .INST_W(INST_W), .EXC_W(EXC_W), .ZERO_BUBBLE(1'b0)
  ) u_dut_b (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (b_flush),
    .bus         (b_if),
    .occupancy_o (b_occ)
  );

  always #5 clk_i = ~clk_i;

  // One clock. At the edge it updates the scoreboard of entries held by instance a, using the
  // inputs as driven, then steps 1 time unit past the edge.
  task automatic tick();
    int pre;
    entry_t e;
    @(posedge clk_i);
    pre = sb.size();
    if (rst_i || a_flush) begin
      sb.delete();
    end else begin
      if (pre > 0 && a_if.dn_ready_i) void'(sb.pop_front());
      if (a_if.up_valid_i && pre < 2) begin
        e.pc   = a_if.up_pc_i;
        e.inst = a_if.up_inst_i;
        e.exc  = a_if.up_exc_i;
        sb.push_back(e);
      end
    end
    #1;
  endtask

  task automatic offer(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                       input logic [EXC_W-1:0] exc);
    a_if.up_valid_i = 1'b1;
    a_if.up_pc_i    = pc;
    a_if.up_inst_i  = inst;
    a_if.up_exc_i   = exc;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    offer(32'hAAAA_0000, 32'h1234_5678, 1'b1);
    a_if.dn_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    a_if.up_valid_i = 1'b0;
    checks++;
    if (a_if.dn_valid_o !== 1'b0 || a_if.dn_pc_o !== '0 || a_if.dn_inst_o !== '0 ||
        a_if.dn_exc_o !== '0)
      begin errors++; $display("FAIL reset_out: got v=%b pc=%h inst=%h exc=%b, want all 0",
        a_if.dn_valid_o, a_if.dn_pc_o, a_if.dn_inst_o, a_if.dn_exc_o); end
    checks++;
    if (a_if.up_ready_o !== 1'b1 || a_occ !== 2'd0)
      begin errors++; $display("FAIL reset_ready: got rdy=%b occ=%0d, want rdy=1 occ=0",
        a_if.up_ready_o, a_occ); end
  endtask

  task automatic test_stream();
    a_if.dn_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
      tick();
      checks++;
      if (a_if.dn_valid_o !== 1'b1 || a_if.dn_pc_o !== 32'h100 + 32'(4 * i) ||
          a_if.dn_inst_o !== 32'h1000 + 32'(i))
        begin errors++; $display("FAIL stream_%0d: got v=%b pc=%h inst=%h, want v=1 pc=%h",
          i, a_if.dn_valid_o, a_if.dn_pc_o, a_if.dn_inst_o, 32'h100 + 32'(4 * i)); end
      checks++;
      if (a_occ !== 2'd1 || a_if.up_ready_o !== 1'b1)
        begin errors++; $display("FAIL stream_occ_%0d: got occ=%0d rdy=%b, want occ=1 rdy=1",
          i, a_occ, a_if.up_ready_o); end
    end
    a_if.up_valid_i = 1'b0;
    tick();
    checks++;
    if (a_if.dn_valid_o !== 1'b0 || a_if.dn_pc_o !== '0 || a_occ !== 2'd0)
      begin errors++; $display("FAIL stream_drain: got v=%b pc=%h occ=%0d, want 0 0 0",
        a_if.dn_valid_o, a_if.dn_pc_o, a_occ); end
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] order [3];
    int k = 0;
    int n_out = 0;
    bit accept_now;
    order[0] = 32'h200; order[1] = 32'h204; order[2] = 32'h208;
    a_if.dn_ready_i = 1'b0;
    offer(32'h200, 32'h2000, 1'b0);
    tick();
    checks++;
    if (a_occ !== 2'd1 || a_if.up_ready_o !== 1'b1 || a_if.dn_pc_o !== 32'h200)
      begin errors++; $display("FAIL bp_one: got occ=%0d rdy=%b pc=%h, want 1 1 200",
        a_occ, a_if.up_ready_o, a_if.dn_pc_o); end
    offer(32'h204, 32'h2004, 1'b0);
    tick();
    offer(32'h208, 32'h2008, 1'b0);
    checks++;
    if (a_occ !== 2'd2 || a_if.up_ready_o !== 1'b0 || a_if.dn_pc_o !== 32'h200)
      begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%b pc=%h, want 2 0 200",
        a_occ, a_if.up_ready_o, a_if.dn_pc_o); end
    tick();
    checks++;
    if (a_occ !== 2'd2 || a_if.up_ready_o !== 1'b0 || a_if.dn_pc_o !== 32'h200)
      begin errors++; $display("FAIL bp_hold: got occ=%0d rdy=%b pc=%h, want 2 0 200",
        a_occ, a_if.up_ready_o, a_if.dn_pc_o); end
    a_if.dn_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (sb.size() > 0) begin
        checks++;
        if (a_if.dn_valid_o !== 1'b1 || k > 2 || a_if.dn_pc_o !== order[k % 3])
          begin errors++; $display("FAIL bp_order_%0d: got v=%b pc=%h, want v=1 pc=%h",
            k, a_if.dn_valid_o, a_if.dn_pc_o, order[k % 3]); end
        k++;
      end
      if (a_if.dn_valid_o === 1'b1) n_out++;
      accept_now = a_if.up_valid_i && (sb.size() < 2);
      tick();
      if (accept_now) a_if.up_valid_i = 1'b0;
    end
    checks++;
    if (n_out != 3 || a_if.dn_valid_o !== 1'b0)
      begin errors++; $display("FAIL bp_count: got %0d outputs v=%b, want 3 outputs v=0",
        n_out, a_if.dn_valid_o); end
  endtask

  task automatic test_flush();
    a_if.dn_ready_i = 1'b0;
    offer(32'h300, 32'h3000, 1'b0);
    tick();
    offer(32'h304, 32'h3004, 1'b1);
    tick();
    a_flush = 1'b1;
    a_if.dn_ready_i = 1'b1;
    offer(32'h308, 32'h3008, 1'b0);
    tick();
    a_flush = 1'b0;
    a_if.up_valid_i = 1'b0;
    checks++;
    if (a_if.dn_valid_o !== 1'b0 || a_if.dn_pc_o !== '0 || a_if.dn_inst_o !== '0 ||
        a_if.dn_exc_o !== '0 || a_occ !== 2'd0 || a_if.up_ready_o !== 1'b1)
      begin errors++; $display("FAIL flush_full: got v=%b pc=%h inst=%h occ=%0d rdy=%b, %s",
        a_if.dn_valid_o, a_if.dn_pc_o, a_if.dn_inst_o, a_occ, a_if.up_ready_o,
        "want v=0 pc=0 inst=0 occ=0 rdy=1"); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (a_if.dn_valid_o !== 1'b0 || a_if.dn_pc_o !== '0)
        begin errors++; $display("FAIL flush_leak_%0d: got v=%b pc=%h, want v=0 pc=0",
          c, a_if.dn_valid_o, a_if.dn_pc_o); end
    end
    // Entry offered while ONE with flush asserted must be dropped as well.
    a_if.dn_ready_i = 1'b0;
    offer(32'h310, 32'h3010, 1'b0);
    tick();
    a_flush = 1'b1;
    offer(32'h314, 32'h3014, 1'b0);
    tick();
    a_flush = 1'b0;
    a_if.up_valid_i = 1'b0;
    tick();
    checks++;
    if (a_if.dn_valid_o !== 1'b0 || a_occ !== 2'd0 || a_if.dn_pc_o !== '0)
      begin errors++; $display("FAIL flush_one: got v=%b occ=%0d pc=%h, want 0 0 0",
        a_if.dn_valid_o, a_occ, a_if.dn_pc_o); end
  endtask

  task automatic test_exc();
    a_if.dn_ready_i = 1'b1;
    offer(32'h500, 32'hDEAD_BEEF, 1'b1);
    tick();
    checks++;
    if (a_if.dn_inst_o !== 32'hDEAD_BEEF || a_if.dn_exc_o !== 1'b1)
      begin errors++; $display("FAIL exc_set: got inst=%h exc=%b, want deadbeef 1",
        a_if.dn_inst_o, a_if.dn_exc_o); end
    offer(32'h504, 32'h0000_0013, 1'b0);
    tick();
    checks++;
    if (a_if.dn_inst_o !== 32'h0000_0013 || a_if.dn_exc_o !== 1'b0)
      begin errors++; $display("FAIL exc_clr: got inst=%h exc=%b, want 00000013 0",
        a_if.dn_inst_o, a_if.dn_exc_o); end
    a_if.up_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_full_zb0();
    a_if.up_valid_i = 1'b0;
    b_if.dn_ready_i = 1'b0;
    b_if.up_valid_i = 1'b1;
    b_if.up_pc_i = 32'h400; b_if.up_inst_i = 32'h4000; b_if.up_exc_i = 1'b1;
    tick();
    b_if.up_pc_i = 32'h404; b_if.up_inst_i = 32'h4004; b_if.up_exc_i = 1'b0;
    tick();
    checks++;
    if (b_occ !== 2'd2 || b_if.up_ready_o !== 1'b0)
      begin errors++; $display("FAIL zb0_full: got occ=%0d rdy=%b, want 2 0",
        b_occ, b_if.up_ready_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    b_if.up_valid_i = 1'b0;
    checks++;
    if (b_if.dn_valid_o !== 1'b0 || b_if.dn_pc_o !== '0 || b_if.dn_inst_o !== '0 ||
        b_if.dn_exc_o !== '0 || b_occ !== 2'd0 || b_if.up_ready_o !== 1'b1)
      begin errors++; $display("FAIL zb0_reset: got v=%b pc=%h inst=%h exc=%b occ=%0d rdy=%b",
        b_if.dn_valid_o, b_if.dn_pc_o, b_if.dn_inst_o, b_if.dn_exc_o, b_occ,
        b_if.up_ready_o); end
    b_if.up_valid_i = 1'b1;
    b_if.up_pc_i = 32'h408; b_if.up_inst_i = 32'h4008; b_if.up_exc_i = 1'b1;
    tick();
    b_if.up_valid_i = 1'b0;
    b_if.dn_ready_i = 1'b1;
    checks++;
    if (b_if.dn_valid_o !== 1'b1 || b_if.dn_pc_o !== 32'h408)
      begin errors++; $display("FAIL zb0_load: got v=%b pc=%h, want v=1 pc=408",
        b_if.dn_valid_o, b_if.dn_pc_o); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (b_if.dn_valid_o !== 1'b0 || b_if.dn_pc_o !== 32'h408 ||
          b_if.dn_inst_o !== 32'h4008 || b_if.dn_exc_o !== 1'b1)
        begin errors++; $display("FAIL zb0_hold_%0d: got v=%b pc=%h inst=%h exc=%b, %s",
          c, b_if.dn_valid_o, b_if.dn_pc_o, b_if.dn_inst_o, b_if.dn_exc_o,
          "want v=0 pc=408 inst=4008 exc=1"); end
    end
    b_if.dn_ready_i = 1'b0;
  endtask

  task automatic test_random();
    logic dr, r1, r2;
    for (int c = 0; c < 10000; c++) begin
      a_if.up_valid_i = ($urandom_range(0, 3) != 0);
      a_if.up_pc_i    = $urandom;
      a_if.up_inst_i  = $urandom;
      a_if.up_exc_i   = 1'($urandom_range(0, 1));
      a_flush         = ($urandom_range(0, 199) == 0);
      dr              = ($urandom_range(0, 3) != 0);
      // Wiggle dn_ready_i within the cycle; up_ready_o must not follow it.
      a_if.dn_ready_i = ~dr;
      #1;
      r1 = a_if.up_ready_o;
      a_if.dn_ready_i = dr;
      #1;
      r2 = a_if.up_ready_o;
      checks++;
      if (r1 !== r2 || r2 !== (sb.size() < 2))
        begin errors++; $display("FAIL rnd_ready cyc %0d: got %b/%b, want %b",
          c, r1, r2, sb.size() < 2); end
      checks++;
      if (a_occ !== 2'(sb.size()) || a_occ > 2'd2)
        begin errors++; $display("FAIL rnd_occ cyc %0d: got %0d, want %0d",
          c, a_occ, sb.size()); end
      checks++;
      if (a_if.dn_valid_o !== (sb.size() > 0))
        begin errors++; $display("FAIL rnd_valid cyc %0d: got %b, want %b",
          c, a_if.dn_valid_o, sb.size() > 0); end
      checks++;
      if (sb.size() > 0) begin
        if (a_if.dn_pc_o !== sb[0].pc || a_if.dn_inst_o !== sb[0].inst ||
            a_if.dn_exc_o !== sb[0].exc)
          begin errors++; $display("FAIL rnd_data cyc %0d: got %h/%h/%b, want %h/%h/%b",
            c, a_if.dn_pc_o, a_if.dn_inst_o, a_if.dn_exc_o, sb[0].pc, sb[0].inst,
            sb[0].exc); end
      end else begin
        if (a_if.dn_pc_o !== '0 || a_if.dn_inst_o !== '0 || a_if.dn_exc_o !== '0)
          begin errors++; $display("FAIL rnd_bubble cyc %0d: got %h/%h/%b, want 0/0/0",
            c, a_if.dn_pc_o, a_if.dn_inst_o, a_if.dn_exc_o); end
      end
      tick();
    end
    a_flush = 1'b0;
    a_if.up_valid_i = 1'b0;
    a_if.dn_ready_i = 1'b1;
    tick();
    tick();
    checks++;
    if (a_occ !== 2'd0 || sb.size() != 0)
      begin errors++; $display("FAIL rnd_drain: got occ=%0d model=%0d, want 0 0",
        a_occ, sb.size()); end
  endtask

  initial begin
    rst_i = 1'b1;
    a_flush = 1'b0;
    b_flush = 1'b0;
    a_if.up_valid_i = 1'b0; a_if.up_pc_i = '0; a_if.up_inst_i = '0; a_if.up_exc_i = '0;
    a_if.dn_ready_i = 1'b0;
    b_if.up_valid_i = 1'b0; b_if.up_pc_i = '0; b_if.up_inst_i = '0; b_if.up_exc_i = '0;
    b_if.dn_ready_i = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_exc();
    test_reset_full_zb0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
